// File: rtl/mano_timing_ctrl_pkg.sv
// Shared constants and types for the MANO timing and run-control stage.
package mano_timing_ctrl_pkg;

  localparam int SC_W = 4;
  localparam int T_W  = 16;

  // Timing index names, so t[T2] reads like the textbook's T2.
  localparam int T0  = 0;
  localparam int T1  = 1;
  localparam int T2  = 2;
  localparam int T3  = 3;
  localparam int T4  = 4;
  localparam int T5  = 5;
  localparam int T6  = 6;
  localparam int T7  = 7;
  localparam int T8  = 8;
  localparam int T9  = 9;
  localparam int T10 = 10;
  localparam int T11 = 11;
  localparam int T12 = 12;
  localparam int T13 = 13;
  localparam int T14 = 14;
  localparam int T15 = 15;

  // Run flag S, held as a two-state machine so it can be observed directly.
  typedef enum logic {
    ST_HALT = 1'b0,
    ST_RUN  = 1'b1
  } run_state_t;

  // Sequence counter increment, modulo 2**SC_W (carry discarded).
  function automatic logic [SC_W-1:0] sc_inc(input logic [SC_W-1:0] v);
    return v + SC_W'(1);
  endfunction

endpackage

// File: rtl/mano_timing_ctrl_if.sv
// Control/flag inputs and timing outputs of the timing stage, bundled.
// Handshake: none. Every signal is a plain level; inputs are sampled on each
// rising clk edge, outputs sc/s_run are registered and t/r_ld/r_d are
// combinational from the current state and inputs.
interface mano_timing_ctrl_if;
  import mano_timing_ctrl_pkg::*;

  logic            start;
  logic            halt;
  logic            sc_clr;
  logic            ien;
  logic            fgi;
  logic            fgo;
  logic            r_q;
  logic [SC_W-1:0] sc;
  logic [T_W-1:0]  t;
  logic            s_run;
  logic            r_ld;
  logic            r_d;

  // Control unit / flag side: drives requests, observes timing.
  modport master (
    output start, halt, sc_clr, ien, fgi, fgo, r_q,
    input  sc, t, s_run, r_ld, r_d
  );

  // Timing stage side.
  modport slave (
    input  start, halt, sc_clr, ien, fgi, fgo, r_q,
    output sc, t, s_run, r_ld, r_d
  );
endinterface

// File: rtl/mano_timing_ctrl_dec_4to16.sv
// Enable-gated n-to-2**n one-hot decoder; all zeros when disabled.
module mano_dec_4to16 #(
  parameter int N = 4
) (
  input  logic             i_en,
  input  logic [N-1:0]     i_sel,
  output logic [2**N-1:0]  o_onehot
);

  // One-hot decode of i_sel, forced to zero when i_en is low.
  always_comb begin
    o_onehot = '0;
    if (i_en) begin
      o_onehot[i_sel] = 1'b1;
    end
  end

endmodule

// File: rtl/mano_timing_ctrl.sv
// MANO CPU timing and run control: run flag S, sequence counter SC, one-hot
// timing T0..T15 and the load/data pair for the interrupt flip-flop R.
module mano_timing_ctrl
  import mano_timing_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  mano_timing_ctrl_if.slave   bus,
  output run_state_t          o_dbg_state
);

  run_state_t      r_state;
  run_state_t      w_state_nxt;
  logic [SC_W-1:0] r_sc;
  logic [SC_W-1:0] w_sc_nxt;
  logic            w_run;
  logic [T_W-1:0]  w_t;
  logic            w_irq;
  logic            w_rclr;

  assign w_run = (r_state == ST_RUN);

  // State and counter registers; reset aborts any count immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_HALT;
      r_sc    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sc    <= w_sc_nxt;
    end
  end

  // Next S (halt beats start) and next SC (clear beats count, even when halted).
  always_comb begin
    w_state_nxt = r_state;
    w_sc_nxt    = r_sc;
    if (bus.halt) begin
      w_state_nxt = ST_HALT;
    end else if (bus.start) begin
      w_state_nxt = ST_RUN;
    end
    if (bus.sc_clr) begin
      w_sc_nxt = '0;
    end else if (w_run) begin
      w_sc_nxt = sc_inc(r_sc);
    end
  end

  mano_dec_4to16 #(
    .N (SC_W)
  ) u_dec (
    .i_en     (w_run),
    .i_sel    (r_sc),
    .o_onehot (w_t)
  );

  // Interrupt request outside the fetch/decode slots T0..T2, and end of the
  // interrupt cycle at T2 while R is set. r_q keeps the two exclusive.
  assign w_irq  = w_run & ~w_t[T0] & ~w_t[T1] & ~w_t[T2] & bus.ien
                & (bus.fgi | bus.fgo) & ~bus.r_q;
  assign w_rclr = w_run & bus.r_q & w_t[T2];

  assign bus.sc      = r_sc;
  assign bus.t       = w_t;
  assign bus.s_run   = w_run;
  assign bus.r_ld    = w_irq | w_rclr;
  assign bus.r_d     = w_irq;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mano_timing_ctrl.sv
// Testbench for mano_timing_ctrl: directed scenarios plus random traffic,
// checked against an arithmetic model through an expected-output queue.
module tb_mano_timing_ctrl;
  import mano_timing_ctrl_pkg::*;

  localparam int EXP_W = 4 + 16 + 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mano_timing_ctrl_if bus ();
  run_state_t dbg_state;

  mano_timing_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- reference model ----------------
  int unsigned m_sc = 0;
  bit          m_s  = 1'b0;
  logic [EXP_W-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [EXP_W-1:0] model_out(input bit ie, fi, fo, rq);
    logic [15:0] t_m;
    bit irq, rclr;
    t_m  = m_s ? (16'h0001 << m_sc) : 16'h0000;
    irq  = m_s && (m_sc >= 3) && ie && (fi || fo) && !rq;
    rclr = m_s && rq && (m_sc == 2);
    return {4'(m_sc), t_m, m_s, (irq || rclr), irq};
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input bit r, st, hl, cl, ie, fi, fo, rq);
    @(posedge clk);
    #1;
    rst        = r;
    bus.start  = st;
    bus.halt   = hl;
    bus.sc_clr = cl;
    bus.ien    = ie;
    bus.fgi    = fi;
    bus.fgo    = fo;
    bus.r_q    = rq;
    if (r) begin
      m_sc = 0;
      m_s  = 1'b0;
    end
    exp_q.push_back(model_out(ie, fi, fo, rq));
    if (!r) begin
      if (cl)       m_sc = 0;
      else if (m_s) m_sc = (m_sc + 1) % 16;
      if (hl)       m_s = 1'b0;
      else if (st)  m_s = 1'b1;
    end
  endtask

  task automatic idle(input int n, input bit ie, fi, fo, rq);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, ie, fi, fo, rq);
  endtask

  // Reset raised between edges must clear sc and S before the next edge.
  task automatic async_rst_test();
    @(posedge clk);
    #1;
    bus.start  = 0;
    bus.halt   = 0;
    bus.sc_clr = 0;
    bus.ien    = 0;
    bus.fgi    = 0;
    bus.fgo    = 0;
    bus.r_q    = 0;
    #1;
    n_tests++;
    if (bus.sc !== 4'(m_sc) || bus.s_run !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_async_rst: sc=%0d s_run=%b required sc=%0d s_run=1",
               bus.sc, bus.s_run, m_sc);
    end
    #1;
    rst = 1'b1;
    #1;
    n_tests++;
    if (bus.sc !== 4'd0 || bus.s_run !== 1'b0 || bus.t !== 16'h0 || bus.r_ld !== 1'b0) begin
      n_fail++;
      $display("FAIL async_rst: sc=%0d s_run=%b t=%h r_ld=%b required sc=0 s_run=0 t=0000 r_ld=0",
               bus.sc, bus.s_run, bus.t, bus.r_ld);
    end
    m_sc = 0;
    m_s  = 1'b0;
    exp_q.push_back(model_out(0, 0, 0, 0));
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [EXP_W-1:0] e;
    logic [EXP_W-1:0] a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {bus.sc, bus.t, bus.s_run, bus.r_ld, bus.r_d};
      n_tests++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL out_cmp @%0t: sc=%0d t=%h s_run=%b r_ld=%b r_d=%b required sc=%0d t=%h s_run=%b r_ld=%b r_d=%b",
                 $time, a[22:19], a[18:3], a[2], a[1], a[0],
                 e[22:19], e[18:3], e[2], e[1], e[0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bus.start  = 0;
    bus.halt   = 0;
    bus.sc_clr = 0;
    bus.ien    = 0;
    bus.fgi    = 0;
    bus.fgo    = 0;
    bus.r_q    = 0;

    // Reset, then idle with start low.
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    idle(5, 0, 0, 0, 0);

    // Start pulse, then walk T0..T15 and wrap.
    drive(0, 1, 0, 0, 0, 0, 0, 0);
    idle(18, 0, 0, 0, 0);

    // Realign, count to 5, clear, then halt+start together.
    drive(0, 0, 0, 1, 0, 0, 0, 0);
    idle(5, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0, 0, 0);
    drive(0, 1, 1, 0, 0, 0, 0, 0);
    idle(2, 0, 0, 0, 0);
    // sc_clr while halted, then restart.
    drive(0, 0, 0, 1, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 0, 0);

    // Interrupt request across all slots with ien=1, fgi=1, r_q=0.
    idle(16, 1, 1, 0, 0);
    // Same with ien=0: never a request.
    idle(16, 0, 1, 1, 0);
    // Only fgo raised.
    idle(8, 1, 0, 1, 0);
    // R set: load strobe only at T2 with data 0.
    idle(16, 1, 1, 0, 1);

    // Count to 9 and hit reset between edges.
    drive(0, 0, 0, 1, 0, 0, 0, 0);
    idle(9, 0, 0, 0, 0);
    async_rst_test();
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      drive(0,
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 29) == 0),
            ($urandom_range(0, 19) == 0),
            ($urandom_range(0, 3) != 0),
            $urandom_range(0, 1),
            ($urandom_range(0, 2) == 0),
            $urandom_range(0, 1));
      if ($urandom_range(0, 199) == 0) drive(1, 0, 0, 0, 0, 0, 0, 0);
    end

    // Let the monitor drain, then make sure nothing was left unchecked.
    repeat (3) @(posedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
